// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the latch-bank serial reader.
// Parity bits are added by defining REG_BANK_READER_PARITY_EN.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Even parity of a word; callers zero-extend, so words up to 64 bits are supported.
    function automatic logic word_parity(input logic [63:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/reg_bank_bitsel.sv
// Combinational selector for the current serial bit of the shadow snapshot.
// With REG_BANK_READER_PARITY_EN defined, bit index WIDTH returns the word parity.
module reg_bank_bitsel
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int WCW   = 1,
    parameter int BCW   = 1
) (
    input  logic [WIDTH*DEPTH-1:0] shadow_i,
    input  logic [WCW-1:0]         word_cnt_i,
    input  logic [BCW-1:0]         bit_cnt_i,
    output logic                   bit_o
);

    logic [WIDTH-1:0] word;

    always_comb begin
        word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (word_cnt_i == WCW'(k)) word = shadow_i[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        bit_o = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (bit_cnt_i == BCW'(b)) bit_o = word[b];
        end
`ifdef REG_BANK_READER_PARITY_EN
        if (bit_cnt_i == BCW'(WIDTH)) bit_o = word_parity(64'(word));
`endif
    end

endmodule

// File: rtl/reg_bank_reader.sv
// Snapshots DEPTH words of the latch bank and streams them LSB-first over valid/ready.
// Optional per-word parity bit: define REG_BANK_READER_PARITY_EN.
module reg_bank_reader
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*DEPTH-1:0] reg_data,
    output logic                   busy,
    output logic                   sout,
    output logic                   sout_valid,
    input  logic                   sout_ready,
    output logic                   done
);

`ifdef REG_BANK_READER_PARITY_EN
    localparam int BITS_PER_WORD = WIDTH + 1;
`else
    localparam int BITS_PER_WORD = WIDTH;
`endif
    localparam int BCW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BITS_PER_WORD - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(DEPTH - 1);

    state_t                 state_q, state_d;
    logic [WIDTH*DEPTH-1:0] shadow_q, shadow_d;
    logic [WCW-1:0]         word_cnt_q, word_cnt_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   sel_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d   = reg_data;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sout_ready) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (word_cnt_q == WORD_LAST) begin
                            word_cnt_d = '0;
                            state_d    = ST_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    reg_bank_bitsel #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .WCW   (WCW),
        .BCW   (BCW)
    ) u_bitsel (
        .shadow_i   (shadow_q),
        .word_cnt_i (word_cnt_q),
        .bit_cnt_i  (bit_cnt_q),
        .bit_o      (sel_bit)
    );

    assign busy       = (state_q != ST_IDLE);
    assign sout_valid = (state_q == ST_SHIFT);
    assign sout       = sout_valid & sel_bit;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader: a readout model queues expected bits and done
// tokens; a negedge monitor pops and compares on every transfer and done pulse.
module tb_reg_bank_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
`ifdef REG_BANK_READER_PARITY_EN
    localparam int BPW = WIDTH + 1;
`else
    localparam int BPW = WIDTH;
`endif
    localparam int NXFER = DEPTH * BPW;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   sout_ready;
    logic [WIDTH*DEPTH-1:0] reg_data;
    logic                   busy, sout, sout_valid, done;

    reg_bank_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reg_data   (reg_data),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_ready (sout_ready),
        .done       (done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];     // 0/1 = data bit, 2 = done pulse
    int         m_phase = 0;  // 0 idle, 1 streaming, 2 closing
    int         m_left  = 0;
    logic       mon_en  = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_sout  = 1'b0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_readout(input logic [WIDTH*DEPTH-1:0] d);
        for (int w = 0; w < DEPTH; w++) begin
            logic p;
            p = 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                exp_q.push_back({1'b0, d[w*WIDTH + b]});
                p = p ^ d[w*WIDTH + b];
            end
`ifdef REG_BANK_READER_PARITY_EN
            exp_q.push_back({1'b0, p});
`endif
        end
        exp_q.push_back(2'd2);
    endfunction

    // Reference: a readout is a snapshot, NXFER accepted transfers, then one closing cycle.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_phase = 0;
            m_left  = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    push_readout(reg_data);
                    m_left  = NXFER;
                    m_phase = 1;
                end
                1: if (sout_ready) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] e;
            chk("busy", busy, m_phase != 0);
            chk("sout_valid", sout_valid, m_phase == 1);
            chk("done", done, m_phase == 2);
            if (!sout_valid) chk("sout_idle", sout, 1'b0);
            if (prev_stall && sout_valid) chk("sout_hold", sout, prev_sout);
            if (sout_valid && sout_ready) begin
                if (exp_q.size() == 0) chk("extra_bit", 1'b1, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("bit_kind", e[1], 1'b0);
                    chk("bit", sout, e[0]);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) chk("extra_done", 1'b1, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_order", e[1], 1'b1);
                end
            end
            prev_stall = sout_valid && !sout_ready;
            prev_sout  = sout;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (m_phase != 0 && k < lim) begin
            cyc();
            k++;
        end
        chk("idle_timeout", k >= lim, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        sout_ready = 1'b1;
        reg_data   = 32'hA53C0F81;
        cyc();
        mon_en = 1'b1;
        cyc();
        // basic stream: start still high at the first edge after reset release
        rst = 1'b0;
        cyc();
        start = 1'b0;
        wait_idle(200);
        repeat (3) cyc();

        // back-pressure 1,0,0,1 pattern
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 400 && m_phase != 0; i++) begin
            sout_ready = (i % 4 == 0) || (i % 4 == 3);
            cyc();
        end
        sout_ready = 1'b1;
        wait_idle(200);
        repeat (2) cyc();

        // snapshot, and start ignored during the readout
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        reg_data = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle(200);
        repeat (5) cyc();

        // abort after 10 transfers, then a fresh readout
        reg_data = 32'hA53C0F81;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (2) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle(200);

        // start held: back-to-back readouts
        reg_data = 32'h12345678;
        start = 1'b1;
        repeat (2 * (NXFER + 2) + 1) cyc();
        start = 1'b0;
        wait_idle(200);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            reg_data = (WIDTH*DEPTH)'({$urandom, $urandom});
            for (int c = 0; c < 60; c++) begin
                start      = ($urandom_range(0, 3) == 0);
                sout_ready = ($urandom_range(0, 2) != 0);
                rst        = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 9) == 0) reg_data = (WIDTH*DEPTH)'({$urandom, $urandom});
                cyc();
            end
            rst        = 1'b0;
            start      = 1'b0;
            sout_ready = 1'b1;
            wait_idle(200);
        end
        repeat (3) cyc();
        chk("queue_drained", exp_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
Read-side companion to the gated D-latch register bank. It snapshots DEPTH stored words of WIDTH bits when requested, then streams them out one bit per accepted transfer using a valid/ready handshake. A single done pulse closes each readout. It sits between the latch bank outputs and a serial debug/monitor consumer.

Parameters:
WIDTH, 8, bits per stored register word (>=2)
DEPTH, 4, number of register words read per readout (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request a readout; honoured only in IDLE
reg_data  input  WIDTH*DEPTH  flattened latch bank q outputs; word k = reg_data[k*WIDTH +: WIDTH]
busy  output  1  high in SHIFT and DONE
sout  output  1  current serial bit; 0 when sout_valid=0
sout_valid  output  1  sout holds a bit to transfer
sout_ready  input  1  consumer accepts sout this cycle
done  output  1  one-cycle pulse after the last bit is accepted

Behaviour:
- All registers update on the rising edge of clk. rst is synchronous and active-high.
- While rst=1 at an edge: state=IDLE, shadow=0, counters=0. After that edge busy=0, sout=0, sout_valid=0, done=0.
- FSM states:
  - IDLE: start=1 -> shadow<=reg_data, word_cnt<=0, bit_cnt<=0, next state SHIFT. reg_data is sampled only at this edge; later changes do not affect the readout.
  - SHIFT: sout_valid=1; sout=shadow[word_cnt*WIDTH+bit_cnt]. A bit transfers on any edge where sout_valid=1 and sout_ready=1; the counters then advance. With sout_ready=0, sout and the counters hold.
  - DONE: done=1 for exactly one cycle, sout_valid=0, then IDLE unconditionally.
- Order: word 0 first; within a word, LSB first.
- Counters:
  - bit_cnt wraps to 0 after index WIDTH-1 and word_cnt increments.
  - The transfer of the last bit of word DEPTH-1 moves the FSM to DONE.
  - Counter widths are $clog2 of their range, minimum 1.
- Latency: start edge -> first bit valid in the next cycle. A full readout with sout_ready held at 1 takes WIDTH*DEPTH cycles in SHIFT, plus 1 cycle in DONE.
- Boundary conditions:
  - start during SHIFT or DONE is ignored; it is not queued.
  - start held high continuously gives back-to-back readouts, with exactly one IDLE cycle between DONE and the next SHIFT.
  - rst mid-readout aborts immediately; no done pulse is generated.
  - sout_ready with sout_valid=0 has no effect.

Optional Feature:
- Macro: REG_BANK_READER_PARITY_EN.
- Defined: after the WIDTH data bits of each word, one extra bit is sent: the even parity (XOR) of that word. bit_cnt then ranges 0..WIDTH, and a readout is DEPTH*(WIDTH+1) transfers. The parity bit uses the same handshake as data bits.
- Undefined: no parity bits; the stream is pure data and the counts are as above.

Decomposition:
- Package reg_bank_pkg holds:
  - state typedef (IDLE, SHIFT, DONE) as 2-bit enum
  - default WIDTH/DEPTH localparams
  - function for parity of a word
- One natural sub-module: reg_bank_bitsel. It is a combinational mux selecting shadow bit (or the parity bit) from word_cnt/bit_cnt. All sequencing stays in reg_bank_reader.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> busy=0, sout_valid=0, done=0, sout=0; no readout starts until the first edge after rst falls.
- Basic stream: WIDTH=8, DEPTH=4, reg_data=32'hA53C0F81, sout_ready=1, start pulsed -> 32 bits in order 1,0,0,0,0,0,0,1, 1,1,1,1,0,0,0,0, 0,0,1,1,1,1,0,0, 1,0,1,0,0,1,0,1; done high exactly at cycle 34 after start; then busy=0.
- Back-pressure: same data, sout_ready toggled 1,0,0,1,... -> identical 32-bit sequence; sout is stable during every ready=0 cycle; done appears after the 32nd transfer.
- Snapshot and ignore: reg_data changed to 32'h0 and start pulsed again during SHIFT -> stream still equals 32'hA53C0F81; no second readout follows.
- Abort: rst asserted after 10 transfers -> next cycle busy=0, no done; a fresh start restarts at word 0 bit 0.
- Parity (macro defined): reg_data=32'hA53C0F81 -> 36 transfers; parity bits after words 0..3 are 0,0,0,0; done after the 36th transfer.
